// File: rtl/serial_and_collector_if.sv
// serial_and_collector_if: serial bit input and parallel word output of the collector
interface serial_and_collector_if #(parameter int N = 2);
    logic         in_valid;
    logic         in_ready;
    logic         in_bit;
    logic         in_flush;
    logic         out_valid;
    logic         out_ready;
    logic [0:N-1] out_x;
    logic         out_y;
    modport slave (
        input  in_valid, in_bit, in_flush, out_ready,
        output in_ready, out_valid, out_x, out_y
    );
    modport master (
        output in_valid, in_bit, in_flush, out_ready,
        input  in_ready, out_valid, out_x, out_y
    );
endinterface

// File: rtl/serial_and_collector.sv
// serial_and_collector: assembles N serial bits into a word and presents it with its AND-reduction
module serial_and_collector #(
    parameter int N = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_and_collector_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic {FILL, FULL} state_t;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_idx, w_idx_nxt;
    logic          r_acc, w_acc_nxt;
    logic [0:N-1]  r_x, w_x_nxt;
    logic          r_y, w_y_nxt;
    logic          r_valid, w_valid_nxt;
    logic          w_accept;
    assign bus.in_ready  = (r_state == FILL) && !bus.in_flush && rst_n;
    assign bus.out_valid = r_valid;
    assign bus.out_x     = r_x;
    assign bus.out_y     = r_y;
    assign w_accept      = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_acc   <= 1'b1;
            r_x     <= '0;
            r_y     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_valid_nxt = r_valid;
        if (r_state == FILL) begin
            if (bus.in_flush) begin
                w_idx_nxt = '0;
                w_acc_nxt = 1'b1;
                w_x_nxt   = '0;
            end else if (w_accept) begin
                w_x_nxt[r_idx] = bus.in_bit;
                w_acc_nxt      = r_acc & bus.in_bit;
                if (r_idx == CW'(N - 1)) begin
                    w_y_nxt     = r_acc & bus.in_bit;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = FULL;
                    w_idx_nxt   = '0;
                    w_acc_nxt   = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + CW'(1);
                end
            end
        end else if (bus.out_ready) begin
            // word leaves; refill starts only on the following cycle
            w_state_nxt = FILL;
            w_valid_nxt = 1'b0;
            w_x_nxt     = '0;
            w_y_nxt     = 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_and_collector.sv
// tb_serial_and_collector: directed and random checks of three collectors (N=4, N=1, N=3)
module tb_serial_and_collector;
    logic clk;
    logic rst_n;
    logic i_v [3];
    logic i_b [3];
    logic i_f [3];
    logic o_r [3];
    logic [0:3] d_x [3];
    logic d_y [3];
    logic d_v [3];
    logic d_rdy [3];
    int errs = 0;
    int checks = 0;
    int nwords = 0;
    bit rnd = 0;
    logic [0:2] expq [$];

    logic [0:3] part [3];
    logic [0:3] word [3];
    int cnt [3];
    bit full [3];
    bit wy [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int N = (g == 0) ? 4 : (g == 1) ? 1 : 3;
        serial_and_collector_if #(.N(N)) bus ();
        logic [0:3] x;
        assign bus.in_valid  = i_v[g];
        assign bus.in_bit    = i_b[g];
        assign bus.in_flush  = i_f[g];
        assign bus.out_ready = o_r[g];
        always_comb begin
            x = '0;
            for (int k = 0; k < N; k++) x[k] = bus.out_x[k];
        end
        assign d_x[g]   = x;
        assign d_y[g]   = bus.out_y;
        assign d_v[g]   = bus.out_valid;
        assign d_rdy[g] = bus.in_ready;
        serial_and_collector #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nv(int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : 3;
    endfunction

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // word-level model: bits received so far, and the completed word awaiting the consumer
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int g = 0; g < 3; g++)
            if (!rst_n) begin
                part[g] = '0; word[g] = '0; cnt[g] = 0; full[g] = 0; wy[g] = 0;
            end else if (full[g]) begin
                if (o_r[g]) begin full[g] = 0; word[g] = '0; wy[g] = 0; end
            end else if (i_f[g]) begin
                part[g] = '0; cnt[g] = 0;
            end else if (i_v[g]) begin
                part[g][cnt[g]] = i_b[g];
                cnt[g]++;
                if (cnt[g] == nv(g)) begin
                    word[g] = part[g];
                    wy[g]   = ($countones(part[g]) == nv(g));
                    full[g] = 1;
                    part[g] = '0;
                    cnt[g]  = 0;
                end
            end
    end

    initial forever begin
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            automatic logic [0:3] ex = full[g] ? word[g] : part[g];
            chk($sformatf("u%0d_valid", g), 8'(d_v[g]), 8'(full[g]));
            chk($sformatf("u%0d_x", g), 8'(d_x[g]), 8'(ex));
            chk($sformatf("u%0d_y", g), 8'(d_y[g]), 8'(full[g] && wy[g]));
            chk($sformatf("u%0d_ready", g), 8'(d_rdy[g]), 8'(rst_n && !full[g] && !i_f[g]));
        end
        if (rst_n && d_v[2] && o_r[2]) begin
            if (expq.size() == 0) chk("sb_extra_word", 8'(d_x[2][0:2]), 8'hff);
            else begin
                automatic logic [0:2] w = expq.pop_front();
                chk("sb_word", 8'(d_x[2][0:2]), 8'(w));
                chk("sb_and", 8'(d_y[2]), 8'(&w));
            end
            nwords++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd) o_r[2] = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [0:3] bits);
        for (int k = 0; k < 4; k++) begin
            i_v[0] = 1'b1;
            i_b[0] = bits[k];
            tick();
        end
        i_v[0] = 1'b0;
    endtask

    task automatic send_rnd(input logic b);
        bit done = 0;
        int t = 0;
        while (!done && t < 100) begin
            i_v[2] = ($urandom_range(0, 3) != 0);
            i_b[2] = b;
            @(negedge clk);
            done = i_v[2] && d_rdy[2];
            tick();
            t++;
        end
        i_v[2] = 1'b0;
        chk("rnd_accept", 8'(done), 8'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            i_v[g] = 0; i_b[g] = 0; i_f[g] = 0; o_r[g] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 8'(d_v[0]), 8'd0);
        chk("rst_x", 8'(d_x[0]), 8'd0);
        chk("rst_ready", 8'(d_rdy[0]), 8'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 8'(d_rdy[0]), 8'd1);

        o_r[0] = 1'b1;
        send4(4'b1101);
        chk("t1_valid", 8'(d_v[0]), 8'd1);
        chk("t1_x", 8'(d_x[0]), 8'b1101);
        chk("t1_y", 8'(d_y[0]), 8'd0);
        tick();
        chk("t1_drop", 8'(d_v[0]), 8'd0);

        o_r[0] = 1'b0;
        send4(4'b1111);
        i_v[0] = 1'b1;
        i_b[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("t2_hold_v", 8'(d_v[0]), 8'd1);
            chk("t2_hold_x", 8'({d_x[0], d_y[0], d_rdy[0]}), 8'b111110);
            if (c < 5) tick();
        end
        o_r[0] = 1'b1;
        tick();
        chk("t2_back_fill", 8'({d_v[0], d_rdy[0]}), 8'b01);
        tick();
        chk("t2_fifth_bit", 8'(d_x[0]), 8'b1000);
        i_v[0] = 1'b0;

        i_f[0] = 1'b1;
        tick();
        i_f[0] = 1'b0;
        chk("t3_clear", 8'(d_x[0]), 8'd0);
        for (int k = 0; k < 2; k++) begin i_v[0] = 1; i_b[0] = 1; tick(); end
        i_f[0] = 1'b1;
        #1;
        chk("t3_flush_ready", 8'(d_rdy[0]), 8'd0);
        tick();
        i_f[0] = 1'b0;
        chk("t3_flushed", 8'(d_x[0]), 8'd0);
        send4(4'b1011);
        chk("t3_x", 8'({d_v[0], d_x[0], d_y[0]}), 8'b110110);
        tick();
        chk("t3_drop", 8'(d_v[0]), 8'd0);

        o_r[1] = 1'b1;
        i_v[1] = 1'b1;
        i_b[1] = 1'b1;
        tick();
        chk("n1_w1", 8'({d_v[1], d_x[1][0], d_y[1]}), 8'b111);
        i_b[1] = 1'b0;
        tick();
        chk("n1_gap", 8'({d_v[1], d_rdy[1]}), 8'b01);
        tick();
        chk("n1_w2", 8'({d_v[1], d_x[1][0], d_y[1]}), 8'b100);
        i_v[1] = 1'b0;
        tick();
        chk("n1_drop", 8'(d_v[1]), 8'd0);

        for (int k = 0; k < 3; k++) begin i_v[0] = 1; i_b[0] = 1; tick(); end
        i_v[0] = 1'b0;
        chk("t5_partial", 8'(d_x[0]), 8'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async", 8'({d_v[0], d_x[0], d_y[0], d_rdy[0]}), 8'd0);
        tick();
        rst_n = 1'b1;
        send4(4'b0111);
        chk("t5_x", 8'({d_v[0], d_x[0], d_y[0]}), 8'b101110);
        tick();

        rnd = 1'b1;
        for (int w = 0; w < 200; w++) begin
            automatic logic [0:2] bits;
            for (int k = 0; k < 3; k++) bits[k] = ($urandom_range(0, 3) != 0);
            expq.push_back(bits);
            for (int k = 0; k < 3; k++) send_rnd(bits[k]);
        end
        rnd = 1'b0;
        o_r[2] = 1'b1;
        for (int c = 0; c < 50 && nwords < 200; c++) tick();
        chk("sb_count", 8'(nwords), 8'd200);
        chk("sb_left", 8'(expq.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
